// File: rtl/seg_scan_disp.sv
// seg_scan_disp: six-digit multiplexed 7-segment scan driver with ghost guard, leading-zero blanking and blink
module seg_scan_disp #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [23:0] i_bcd,
  input  logic [5:0]  i_dp,
  input  logic [5:0]  i_blink,
  input  logic        i_lzb,
  output logic [5:0]  o_seg_enb,
  output logic        o_seg_dp,
  output logic [6:0]  o_seg
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_DIV + 1);
  logic [SW-1:0] scan_q;
  logic [2:0]    dig_q;
  logic [FW-1:0] frame_q;
  logic          ph_q;
  logic [23:0]   bcd_q;
  logic [5:0]    dp_q, blink_q;
  logic          slot_end, wrap, frame_end, blank;
  logic [23:0]   bcd_sh;
  logic [5:0]    dp_sh, blink_sh, lz, lz_sh;
  logic [5:0]    enb_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  function automatic logic [6:0] font(input logic [3:0] c);
    case (c)
      4'd0: font = 7'h7E;
      4'd1: font = 7'h30;
      4'd2: font = 7'h6D;
      4'd3: font = 7'h79;
      4'd4: font = 7'h33;
      4'd5: font = 7'h5B;
      4'd6: font = 7'h5F;
      4'd7: font = 7'h70;
      4'd8: font = 7'h7F;
      4'd9: font = 7'h7B;
      default: font = 7'h01;
    endcase
  endfunction
  assign slot_end  = scan_q == SW'(SCAN_DIV - 1);
  assign wrap      = dig_q == 3'd5;
  assign frame_end = frame_q == FW'(BLINK_DIV - 1);
  // lz[k]: digits k..5 are all zero with no decimal point requested
  always_comb begin
    lz[5] = bcd_q[23:20] == 4'd0 && !dp_q[5];
    for (int i = 4; i >= 0; i--) lz[i] = lz[i+1] && bcd_q[4*i +: 4] == 4'd0 && !dp_q[i];
  end
  assign bcd_sh   = bcd_q >> {dig_q, 2'b00};
  assign dp_sh    = dp_q >> dig_q;
  assign blink_sh = blink_q >> dig_q;
  assign lz_sh    = lz >> dig_q;
  assign blank    = scan_q < SW'(GUARD) || (blink_sh[0] && ph_q) || (i_lzb && dig_q != 3'd0 && lz_sh[0]);
  assign enb_d    = blank ? 6'h3F : ~(6'b1 << dig_q);
  assign seg_d    = blank ? 7'h00 : font(bcd_sh[3:0]);
  assign dp_d     = !blank && dp_sh[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= '0;
      dig_q     <= '0;
      frame_q   <= '0;
      ph_q      <= 1'b0;
      bcd_q     <= '0;
      dp_q      <= '0;
      blink_q   <= '0;
      o_seg_enb <= 6'h3F;
      o_seg     <= '0;
      o_seg_dp  <= 1'b0;
    end else begin
      scan_q <= slot_end ? '0 : scan_q + 1'b1;
      if (slot_end) dig_q <= wrap ? 3'd0 : dig_q + 3'd1;
      if (slot_end && wrap) begin
        frame_q <= frame_end ? '0 : frame_q + 1'b1;
        if (frame_end) ph_q <= ~ph_q;
      end
      if (i_load) begin
        bcd_q   <= i_bcd;
        dp_q    <= i_dp;
        blink_q <= i_blink;
      end
      o_seg_enb <= enb_d;
      o_seg     <= seg_d;
      o_seg_dp  <= dp_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_disp.sv
// tb_seg_scan_disp: directed stimulus with a time-based display model checked every cycle
module tb_seg_scan_disp;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BD = 2;
  localparam logic [6:0] FONT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic        clk = 1'b0, rst = 1'b1, i_load = 1'b0, i_lzb = 1'b0;
  logic [23:0] i_bcd = '0;
  logic [5:0]  i_dp = '0, i_blink = '0;
  logic [5:0]  o_seg_enb;
  logic        o_seg_dp;
  logic [6:0]  o_seg;
  int checks = 0, errors = 0;
  int t_m = 0, s_t = 0;
  logic [23:0] m_bcd = '0, s_bcd = '0;
  logic [5:0]  m_dp = '0, s_dp = '0, m_bl = '0, s_bl = '0;
  logic        s_lzb = 1'b0, s_rst = 1'b0, s_valid = 1'b0;

  seg_scan_disp #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_bcd(i_bcd), .i_dp(i_dp), .i_blink(i_blink),
    .i_lzb(i_lzb), .o_seg_enb(o_seg_enb), .o_seg_dp(o_seg_dp), .o_seg(o_seg)
  );

  always #5 clk = ~clk;

  // Time since reset fully determines the scan position; shadow data is what was loaded before this edge
  always @(posedge clk) begin
    s_rst <= rst;
    s_t   <= t_m;
    s_bcd <= m_bcd;
    s_dp  <= m_dp;
    s_bl  <= m_bl;
    s_lzb <= i_lzb;
    if (rst) s_valid <= 1'b1;
    t_m   <= rst ? 0 : t_m + 1;
    m_bcd <= rst ? 24'h0 : i_load ? i_bcd : m_bcd;
    m_dp  <= rst ? 6'h0 : i_load ? i_dp : m_dp;
    m_bl  <= rst ? 6'h0 : i_load ? i_blink : m_bl;
  end

  function automatic logic [13:0] model(input int t, input logic [23:0] b, input logic [5:0] dp, input logic [5:0] bl, input logic lz);
    int slot, scan, dig;
    bit ph, blank;
    logic [23:0] hi;
    logic [5:0] dph, one;
    logic [3:0] code;
    slot = t / SD;
    scan = t % SD;
    dig = slot % 6;
    ph = ((slot / 6 / BD) % 2) == 1;
    hi = b >> (4 * dig);
    dph = dp >> dig;
    code = hi[3:0];
    one = 6'b1;
    blank = scan < GD || (bl[dig] && ph) || (lz && dig > 0 && hi == 0 && dph == 0);
    return blank ? {6'h3F, 8'h00} : {~(one << dig), dp[dig], code > 9 ? 7'h01 : FONT[code]};
  endfunction

  task automatic tick();
    logic [13:0] exp;
    @(negedge clk);
    if (s_valid) begin
      exp = s_rst ? {6'h3F, 8'h00} : model(s_t, s_bcd, s_dp, s_bl, s_lzb);
      checks++;
      if ({o_seg_enb, o_seg_dp, o_seg} !== exp) begin
        errors++;
        $display("FAIL model t=%0d enb/dp/seg got %b/%b/%h want %b/%b/%h", s_t,
                 o_seg_enb, o_seg_dp, o_seg, exp[13:8], exp[7], exp[6:0]);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_enb(input string nm, input logic [5:0] tg, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (o_seg_enb == tg) ok = 1'b1;
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic load(input logic [23:0] b, input logic [5:0] dp, input logic [5:0] bl);
    i_bcd = b;
    i_dp = dp;
    i_blink = bl;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  initial begin
    int n0, n1, bad;
    repeat (3) tick();
    chk("rst_enb", o_seg_enb, 6'h3F);
    chk("rst_seg", o_seg, 7'h00);
    chk("rst_dp", o_seg_dp, 1'b0);
    rst = 1'b0;
    tick();
    chk("first_guard", o_seg_enb, 6'h3F);
    tick();
    chk("first_lit_enb", o_seg_enb, 6'b111110);
    chk("first_lit_seg", o_seg, 7'h7E);
    // scan of 543210
    load(24'h543210, 6'h00, 6'h00);
    wait_enb("scan_d1", 6'b111101, 30);
    chk("scan_d1_seg", o_seg, 7'h30);
    wait_enb("scan_d5", 6'b011111, 30);
    chk("scan_d5_seg", o_seg, 7'h5B);
    wait_enb("scan_wrap", 6'b111110, 30);
    chk("scan_wrap_seg", o_seg, 7'h7E);
    repeat (30) tick();
    // leading-zero blanking
    i_lzb = 1'b1;
    load(24'h000042, 6'h00, 6'h00);
    tick();
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (o_seg_enb[5:2] != 4'hF) bad++;
    end
    chk("lzb_hidden", bad, 0);
    load(24'h000042, 6'b001000, 6'h00);
    wait_enb("lzb_d3", 6'b110111, 30);
    chk("lzb_d3_dp", o_seg_dp, 1'b1);
    chk("lzb_d3_seg", o_seg, 7'h7E);
    wait_enb("lzb_d2", 6'b111011, 30);
    chk("lzb_d2_dp", o_seg_dp, 1'b0);
    chk("lzb_d2_seg", o_seg, 7'h7E);
    // blink on digit 0: one full blink period is 96 cycles
    i_lzb = 1'b0;
    load(24'h543210, 6'h00, 6'b000001);
    tick();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      if (o_seg_enb == 6'b111110) n0++;
      if (o_seg_enb == 6'b111101) n1++;
    end
    chk("blink_d0", n0, 6);
    chk("blink_d1", n1, 12);
    // load coinciding with slot advance from digit 5 to digit 0
    for (int i = 0; i < 30 && t_m % 24 != 23; i++) tick();
    chk("race_align", t_m % 24, 23);
    load(24'h54321C, 6'h00, 6'h00);
    tick();
    chk("race_guard", o_seg_enb, 6'h3F);
    tick();
    chk("race_enb", o_seg_enb, 6'b111110);
    chk("race_seg", o_seg, 7'h01);
    repeat (20) tick();
    // reset in the middle of digit 3's slot
    for (int i = 0; i < 30 && t_m % 24 != 14; i++) tick();
    chk("mid_align", t_m % 24, 14);
    rst = 1'b1;
    tick();
    chk("mid_rst_enb", o_seg_enb, 6'h3F);
    chk("mid_rst_seg", o_seg, 7'h00);
    chk("mid_rst_dp", o_seg_dp, 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_guard", o_seg_enb, 6'h3F);
    tick();
    chk("mid_restart_enb", o_seg_enb, 6'b111110);
    chk("mid_restart_seg", o_seg, 7'h7E);
    repeat (30) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
